// File: rtl/gray_ptr_fifo.sv
// Single-clock circular FIFO with Gray-coded pointers and registered full/empty flags.
// Latency: 1-cycle read data; empty/full clear 1 edge after the opposite side moves (3 with FIFO_PTR_SYNC_EN).
// Backpressure: writes ignored while wr_full, reads ignored while rd_empty; flags are conservative.
module gray_ptr_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_empty
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_bin, wr_ptr_gray, wr_bin_next, wr_gray_next;
    logic [PW-1:0] rd_ptr_bin, rd_ptr_gray, rd_bin_next, rd_gray_next;
    logic [PW-1:0] wr_ptr_seen, rd_ptr_seen;
    logic          wr_accept, rd_accept;

    assign wr_accept    = wr_en & ~wr_full;
    assign rd_accept    = rd_en & ~rd_empty;
    assign wr_bin_next  = wr_ptr_bin + {{(PW-1){1'b0}}, wr_accept};
    assign rd_bin_next  = rd_ptr_bin + {{(PW-1){1'b0}}, rd_accept};
    assign wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);
    assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);

`ifdef FIFO_PTR_SYNC_EN
    logic [PW-1:0] wr_ptr_gray_sync1, wr_ptr_gray_sync2;
    logic [PW-1:0] rd_ptr_gray_sync1, rd_ptr_gray_sync2;

    // Two-stage copies keep the structure identical to the dual-clock variant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_gray_sync1 <= '0;
            wr_ptr_gray_sync2 <= '0;
            rd_ptr_gray_sync1 <= '0;
            rd_ptr_gray_sync2 <= '0;
        end else begin
            wr_ptr_gray_sync1 <= wr_ptr_gray;
            wr_ptr_gray_sync2 <= wr_ptr_gray_sync1;
            rd_ptr_gray_sync1 <= rd_ptr_gray;
            rd_ptr_gray_sync2 <= rd_ptr_gray_sync1;
        end
    end

    assign wr_ptr_seen = wr_ptr_gray_sync2;
    assign rd_ptr_seen = rd_ptr_gray_sync2;
`else
    assign wr_ptr_seen = wr_ptr_gray;
    assign rd_ptr_seen = rd_ptr_gray;
`endif

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_bin[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_bin  <= '0;
            wr_ptr_gray <= '0;
            wr_full     <= 1'b0;
        end else begin
            wr_ptr_bin  <= wr_bin_next;
            wr_ptr_gray <= wr_gray_next;
            // Full: Gray pointers differ only in the two MSBs (one lap apart).
            wr_full     <= (wr_gray_next == {~rd_ptr_seen[PW-1:PW-2], rd_ptr_seen[PW-3:0]});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_bin  <= '0;
            rd_ptr_gray <= '0;
            rd_empty    <= 1'b1;
            rd_data     <= '0;
        end else begin
            rd_ptr_bin  <= rd_bin_next;
            rd_ptr_gray <= rd_gray_next;
            rd_empty    <= (rd_gray_next == wr_ptr_seen);
            if (rd_accept) begin
                rd_data <= mem[rd_ptr_bin[ADDR_WIDTH-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_gray_ptr_fifo.sv
// Self-checking bench for gray_ptr_fifo: directed scenarios plus random traffic against a queue model.
module tb_gray_ptr_fifo;
`ifdef FIFO_PTR_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_full;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_empty;

    gray_ptr_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored words plus accepted-transfer counts.
    logic [7:0] q[$];
    int         wcnt, rcnt;
    int         whist[LAT+1];
    int         rhist[LAT+1];
    logic [7:0] exp_rd;
    logic       exp_empty, exp_full;
    int         n_cmp = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        q.delete();
        wcnt = 0; rcnt = 0;
        for (int i = 0; i <= LAT; i++) begin whist[i] = 0; rhist[i] = 0; end
        exp_rd = 8'h00; exp_empty = 1'b1; exp_full = 1'b0;
    endtask

    task automatic model_edge(input logic we, input logic [7:0] wd, input logic re);
        logic acc_w, acc_r;
        acc_w = we && !exp_full;
        acc_r = re && !exp_empty;
        if (acc_r && q.size() > 0) begin exp_rd = q.pop_front(); rcnt++; end
        if (acc_w) begin q.push_back(wd); wcnt++; end
        for (int i = LAT; i > 0; i--) begin whist[i] = whist[i-1]; rhist[i] = rhist[i-1]; end
        whist[0] = wcnt; rhist[0] = rcnt;
        // Flags see the opposite side's count as it was LAT edges ago.
        exp_empty = (whist[LAT] == rcnt);
        exp_full  = ((wcnt - rhist[LAT]) == DEPTH);
    endtask

    task automatic step(input logic we, input logic [7:0] wd, input logic re);
        @(negedge clk);
        wr_en = we; wr_data = wd; rd_en = re;
        @(posedge clk);
        model_edge(we, wd, re);
        #1;
        chk("rd_empty", int'(rd_empty), int'(exp_empty));
        chk("wr_full",  int'(wr_full),  int'(exp_full));
        chk("rd_data",  int'(rd_data),  int'(exp_rd));
    endtask

    task automatic chk_ptrs();
        chk("wr_ptr_bin",  int'(dut.wr_ptr_bin),  wcnt % 32);
        chk("wr_ptr_gray", int'(dut.wr_ptr_gray), gray(wcnt % 32));
        chk("rd_ptr_bin",  int'(dut.rd_ptr_bin),  rcnt % 32);
        chk("rd_ptr_gray", int'(dut.rd_ptr_gray), gray(rcnt % 32));
    endtask

    task automatic wait_data(input int budget);
        int n;
        n = 0;
        while (exp_empty && n < budget) begin step(1'b0, 8'h00, 1'b0); n++; end
        chk("wait_data_timeout", int'(exp_empty), 0);
    endtask

    initial begin
        int nw;
        model_reset();
        // Reset state
        rst = 1'b1;
        #12;
        chk("rst_empty", int'(rd_empty), 1);
        chk("rst_full", int'(wr_full), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        chk_ptrs();
        @(negedge clk); rst = 1'b0;

        // Read on empty FIFO is ignored
        step(1'b0, 8'h00, 1'b1);
        chk_ptrs();

        // A0..A7 with random gaps, then drain 8
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'hA0 + 8'(i), 1'b0);
            repeat ($urandom_range(0, 2)) step(1'b0, 8'h00, 1'b0);
        end
        chk("gray_after_8", int'(dut.wr_ptr_gray), 5'b01100);
        wait_data(10);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        chk("drained_empty", int'(rd_empty), 1);
        chk("last_A", int'(rd_data), 8'hA7);
        chk_ptrs();

        // Alternating single write / read
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'h50 + 8'(i), 1'b0);
            wait_data(10);
            step(1'b0, 8'h00, 1'b1);
            chk("alt_data", int'(rd_data), 8'h50 + i);
        end

        // Fill 16, try a 17th, drain 16
        repeat (LAT + 1) step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b1, 8'h30 + 8'(i), 1'b0);
        chk("full_after_16", int'(wr_full), 1);
        step(1'b1, 8'hFF, 1'b0);
        chk("ptr_after_17th", int'(dut.wr_ptr_bin), wcnt % 32);
        wait_data(10);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
        chk("last_3F", int'(rd_data), 8'h3F);
        step(1'b0, 8'h00, 1'b0);
        chk("fill_drained_empty", int'(rd_empty), 1);
        chk_ptrs();

        // Interleaved C0..C9: writes every 4 cycles, reads every 6 cycles
        nw = 0;
        for (int c = 0; c < 120; c++) begin
            logic we, re;
            we = (c % 4 == 0) && (nw < 10);
            re = (c % 6 == 0) && !exp_empty;
            step(we, 8'hC0 + 8'(nw), re);
            if (we) nw++;
        end
        chk("interleave_count", rcnt - wcnt, 0);
        chk("last_C9", int'(rd_data), 8'hC9);
        chk_ptrs();

        // Random traffic: write-heavy then read-heavy phases
        for (int c = 0; c < 600; c++) begin
            logic we, re;
            if ((c / 100) % 2 == 0) begin
                we = ($urandom_range(0, 3) != 0);
                re = ($urandom_range(0, 3) == 0);
            end else begin
                we = ($urandom_range(0, 3) == 0);
                re = ($urandom_range(0, 3) != 0);
            end
            step(we, 8'($urandom), re);
        end
        chk_ptrs();

        // Reset while holding 5 words
        repeat (LAT + 1) step(1'b0, 8'h00, 1'b1);
        while (!exp_empty) step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h70 + 8'(i), 1'b0);
        wait_data(10);
        step(1'b0, 8'h00, 1'b1);
        chk("pre_rst_data", int'(rd_data), 8'h70);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_empty", int'(rd_empty), 1);
        chk("midrst_full", int'(wr_full), 0);
        chk("midrst_data", int'(rd_data), 0);
        chk_ptrs();
        @(negedge clk); rst = 1'b0;
        step(1'b1, 8'h9A, 1'b0);
        wait_data(10);
        step(1'b0, 8'h00, 1'b1);
        chk("post_rst_data", int'(rd_data), 8'h9A);
        step(1'b0, 8'h00, 1'b0);
        chk("post_rst_empty", int'(rd_empty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/gray_ptr_fifo.md
Name: gray_ptr_fifo

Overview:
- Single-clock circular FIFO buffer: DATA_WIDTH-bit words, depth 2**ADDR_WIDTH.
- Uses Gray-coded read/write pointers and registered full/empty flags.
- Its pointer/flag structure matches the team's dual-clock FIFO, so it can later be split into two clock domains without redesign.
- Sits between a producer and a consumer in the same clock domain.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, address bits. Depth = 2**ADDR_WIDTH (16). Pointers are ADDR_WIDTH+1 bits.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset; release is synchronous to clk upstream.
- wr_en  input  1  write request.
- wr_data  input  DATA_WIDTH  word to write.
- wr_full  output  1  registered; 1 = no space, writes are ignored.
- rd_en  input  1  read request.
- rd_data  output  DATA_WIDTH  registered read word.
- rd_empty  output  1  registered; 1 = no data, reads are ignored.

Behaviour:
- Reset (async, while rst=1):
  - wr_ptr_bin, wr_ptr_gray, rd_ptr_bin, rd_ptr_gray, all sync stages = 0.
  - wr_full=0, rd_empty=1, rd_data=0.
  - Memory contents are not reset.
- Write acceptance:
  - Accepted when wr_en && !wr_full.
  - mem[wr_ptr_bin[ADDR_WIDTH-1:0]] <= wr_data.
  - wr_ptr_bin increments modulo 2**(ADDR_WIDTH+1); wr_ptr_gray <= next_bin ^ (next_bin>>1).
- Write while wr_full: ignored. Pointer and memory unchanged.
- Read acceptance:
  - Accepted when rd_en && !rd_empty.
  - rd_data <= mem[rd_ptr_bin[ADDR_WIDTH-1:0]]; valid on rd_data after that same edge (1-cycle latency).
  - rd_ptr_bin/rd_ptr_gray advance as for the write side.
- Read while rd_empty: ignored. rd_data holds its previous value.
- rd_data changes only on an accepted read.
- Cross-pointer copies: wr_ptr_gray_sync1/sync2 (write pointer seen by the read logic), rd_ptr_gray_sync1/sync2 (read pointer seen by the write logic). Their behaviour depends on FIFO_PTR_SYNC_EN (see Optional Feature).
- rd_empty (registered) = (next rd_ptr_gray == write-pointer copy).
- wr_full (registered) = (next wr_ptr_gray == read-pointer copy with its two MSBs inverted and remaining bits equal).
- Full occurs at exactly 2**ADDR_WIDTH stored words; empty at 0.
- Wrap-around: address uses the low ADDR_WIDTH bits; the extra MSB distinguishes full from empty.
- Simultaneous accepted read and write in one cycle: both take effect; occupancy unchanged.
- Flags are conservative: they may lag, but never report space or data that does not exist. Data order is strictly FIFO.
- rst asserted mid-operation: FIFO empties immediately; stored data is discarded.

Optional Feature:
- Macro: FIFO_PTR_SYNC_EN.
- Defined:
  - Each cross-pointer passes through two flop stages (sync1 -> sync2), and flags use sync2.
  - Write accepted at edge N clears rd_empty at edge N+3.
  - Read accepted at edge N clears wr_full at edge N+3.
  - Gray encoding guarantees that a single bit changes per increment.
- Undefined:
  - Sync stages are removed; flags compare against the live opposite Gray pointer.
  - Write at edge N clears rd_empty at edge N+1; read at edge N clears wr_full at edge N+1.
- Data path and ordering are identical in both builds.

Test Plan:
- Reset -> rd_empty=1, wr_full=0, rd_data=00, all pointers 0. A read on the empty FIFO leaves rd_data=00 and pointers unchanged.
- Write A0..A7 with gaps, wait for rd_empty=0, then read 8 -> rd_data sequence A0..A7 one cycle after each rd_en. rd_empty=1 afterwards. wr_ptr_gray ends at 01100.
- Alternating single writes 50..53, each followed by a read -> each read returns the matching 50+i. rd_empty is never 1 when data was expected (account for the sync latency when FIFO_PTR_SYNC_EN is defined).
- Fill 16 words 30..3F -> wr_full=0 during the first 15 writes, 1 after the 16th. A 17th write of FF is ignored. Draining 16 returns 30..3F in order, and rd_empty=1.
- Interleave 10 writes C0..C9 (one every 4 cycles) with reads (one every 6 cycles, only when !rd_empty) -> reads return C0..C9 in order; pointers wrap past 15 correctly.
- Assert rst while holding 5 words -> immediately rd_empty=1, wr_full=0, rd_data=00. The next write/read pair returns the new word.
